// File: rtl/shift_req_sequencer.sv
// Request FIFO + issue register + result register around an external combinational left shifter.
// Latency: accept at edge k, shf_* valid after k+1, res_valid after k+2; one result per cycle.
// Backpressure: res_ready low freezes result and issue stages; FIFO fills, req_ready drops at DEPTH entries.
module shift_req_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_data,
    input  logic [4:0]               req_amt,
    output logic [31:0]              shf_in,
    output logic [4:0]               shf_sv,
    input  logic [31:0]              shf_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         done_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [31:0]   fifo_data [DEPTH];
    logic [4:0]    fifo_amt  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          iss_valid;

    logic push;
    logic pop;
    logic advance;
    logic drain;

    // A pop in the same cycle does not open a slot while full; keeps req_ready purely registered-state driven.
    assign req_ready = !rst && (fifo_count != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign advance   = iss_valid && (!res_valid || res_ready);
    assign pop       = (fifo_count != '0) && (!iss_valid || advance);
    assign drain     = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= req_data;
            fifo_amt[wr_ptr]  <= req_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            iss_valid  <= 1'b0;
            shf_in     <= '0;
            shf_sv     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            done_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop) begin
                shf_in    <= fifo_data[rd_ptr];
                shf_sv    <= fifo_amt[rd_ptr];
                iss_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (advance) begin
                shf_in    <= '0;
                shf_sv    <= '0;
                iss_valid <= 1'b0;
            end

            if (advance) begin
                res_data  <= shf_out;
                res_valid <= 1'b1;
            end else if (drain) begin
                res_valid <= 1'b0;
            end

            if (drain) begin
                done_count <= done_count + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: doc/shift_req_sequencer.md
# shift_req_sequencer

Upstream feeder for the 32-bit combinational left barrel shifter. The block accepts shift requests (operand plus 5-bit shift amount) over a valid/ready handshake and buffers them in a small FIFO. It issues one request per cycle from a registered issue stage that drives the shifter's `in`/`sv` inputs, then captures the shifter's `out` into a result register presented downstream with valid/ready. The shifter stays purely combinational between this block's issue register and its result register, which gives a two-stage pipeline.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the completed-result counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_data`  in  32  operand to shift.
- `req_amt`  in  5  left-shift amount, 0–31.
- `shf_in`  out  32  registered operand to shifter `in`.
- `shf_sv`  out  5  registered amount to shifter `sv`.
- `shf_out`  in  32  shifter result (combinational from `shf_in`/`shf_sv`).
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  32  shifted result.
- `fifo_count`  out  log2(DEPTH)+1  current FIFO occupancy.
- `done_count`  out  CNT_W  results consumed since reset.

## Operation
- **Push:** occurs when `req_valid && req_ready`. `req_ready = !rst && (fifo_count < DEPTH)`. When full, `req_ready` stays low even if a pop happens in the same cycle.
- **Issue stage:** holds `iss_valid`, `shf_in` and `shf_sv`.
  - Pop condition: FIFO non-empty and (`!iss_valid` or issue advancing). On pop, the FIFO head loads into `shf_in`/`shf_sv` and `iss_valid` is set to 1.
  - If the stage is advancing and nothing is popped, `iss_valid` is cleared to 0 and `shf_in`/`shf_sv` are cleared to 0.
  - `shf_in`/`shf_sv` are 0 whenever `iss_valid` is 0.
- **Issue advance:** `iss_valid && (!res_valid || res_ready)`. On advance, `res_data <= shf_out` and `res_valid` is set to 1.
- **Result drain:** when `res_valid && res_ready` and there is no advance, `res_valid` is cleared to 0. `res_data` holds its last value.
- **Completion count:** `done_count` increments by 1 on each `res_valid && res_ready` and wraps modulo 2^CNT_W.
- **Occupancy:** `fifo_count` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- **FIFO structure:** circular buffer with read/write pointers that wrap at DEPTH.
- **Ordering:** strict FIFO; results appear in acceptance order, with none dropped or duplicated.
- **Data handling:** `req_amt` = 0 passes the operand through. No data-dependent behaviour; bits shifted past bit 31 are the shifter's concern.
- **Capacity:** DEPTH + 2 requests in flight (FIFO plus issue plus result).

## Timing
- **Reset values** (`rst` high at an edge): `res_valid` 0, `res_data` 0, `shf_in` 0, `shf_sv` 0, `fifo_count` 0, `done_count` 0, pointers 0, `iss_valid` 0. `req_ready` is 0 while `rst` is high.
- **Reset mid-operation:** all buffered and in-flight requests are discarded with no result emitted. `req_ready` goes to 1 in the first cycle after `rst` falls.
- **Latency, empty pipeline:**
  - Request accepted at edge k.
  - Issued (`shf_*` valid) after edge k+1.
  - `res_valid` = 1 after edge k+2.
- **Throughput:** one result per cycle while `res_ready` is held high.
- **Backpressure:**
  - `res_ready` low freezes the result register.
  - The issue stage then holds its value.
  - The FIFO fills; `req_ready` falls after DEPTH + 2 total accepts.
- **Recovery:** raising `res_ready` drains one result per cycle. `req_ready` returns to 1 the cycle after the first pop from a full FIFO.

## Test plan
- **Single request:** `req_data` 0x00000001, `req_amt` 31, `res_ready` 1 → `res_data` 0x80000000 with `res_valid` high exactly 2 cycles after accept; `done_count` 1.
- **Streaming:** 8 back-to-back requests with `req_data` 1..8 and `req_amt` 1, `res_ready` 1 → results 2, 4, …, 16 on consecutive cycles, in order; `fifo_count` never exceeds 1.
- **Backpressure fill:** `res_ready` 0 while offering 10 requests → exactly 6 accepted (DEPTH=4), `fifo_count` 4, `req_ready` 0. Then `res_ready` 1 → 6 in-order results, then the remaining requests are accepted.
- **Shift-amount edges:** amount 0 on 0xDEADBEEF → 0xDEADBEEF. Amount 31 on 0x00000003 → 0x80000000. Amount 4 on 0xF0000001 → 0x00000010.
- **Reset mid-operation:** 3 requests in flight, `rst` pulsed for 1 cycle → no `res_valid`, all counters 0. A subsequent request completes normally with 2-cycle latency.
- **Counter wrap:** CNT_W=4, 17 consumed results → `done_count` 1.
